io_input_ctrl: RTL and testbench

IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

---
 rtl/io_input_ctrl.sv | 146 ++++++++++++++
 tb/tb_io_input_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/io_input_ctrl.sv
// Processor input port: show-ahead device FIFO feeding the In bus, plus an
// edge-triggered interrupt pulse generator with hold-off and a 1-deep pending slot.
module io_input_ctrl #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] dev_data,
  input  logic        dev_valid,
  output logic        dev_ready,
  input  logic        irq_req,
  input  logic        in_rd,
  output logic [15:0] In,
  output logic        in_empty,
  output logic        Int,
  output logic        rd_err
);

  localparam int DATA_W = 16;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int HW     = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } irq_state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  irq_state_t        state;
  irq_state_t        state_nxt;
  logic [HW-1:0]     hold_cnt;
  logic [HW-1:0]     hold_nxt;
  logic              pending;
  logic              pending_nxt;
  logic              irq_q;
  logic              rise;
  logic              int_q;

  assign dev_ready = (count != CW'(DEPTH));
  assign in_empty  = (count == '0);
  assign push      = dev_valid && dev_ready;
  assign pop       = in_rd && !in_empty;
  assign In        = in_empty ? '0 : mem[rd_ptr];

  // FIFO storage: data only, never reset; reset-cycle pushes are dropped
  always_ff @(posedge Clk) begin
    if (Rst && push) begin
      mem[wr_ptr] <= dev_data;
    end
  end

  // FIFO control: power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (in_rd && in_empty) begin
        rd_err <= 1'b1;
      end
    end
  end

  assign rise = irq_req && !irq_q;

  // An edge arriving on the last hold cycle is treated as pending so it is not lost
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        state_nxt = HOLD;
        hold_nxt  = HW'(HOLDOFF - 1);
        if (rise) begin
          pending_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          if (pending || rise) begin
            state_nxt   = FIRE;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          hold_nxt = hold_cnt - HW'(1);
          if (rise) begin
            pending_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // irq_q follows irq_req through reset so a level already high at release is not an edge
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pending  <= 1'b0;
      irq_q    <= irq_req;
      int_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      pending  <= pending_nxt;
      irq_q    <= irq_req;
      int_q    <= (state_nxt == FIRE);
    end
  end

  assign Int = int_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl: directed scenarios plus random traffic, every cycle
// compared against a queue/timestamp reference model.
module tb_io_input_ctrl;
  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] dev_data = '0;
  logic        dev_valid = 1'b0;
  logic        dev_ready;
  logic        irq_req = 1'b0;
  logic        in_rd = 1'b0;
  logic [15:0] In;
  logic        in_empty;
  logic        Int;
  logic        rd_err;

  io_input_ctrl #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .Clk(Clk), .Rst(Rst), .dev_data(dev_data), .dev_valid(dev_valid),
    .dev_ready(dev_ready), .irq_req(irq_req), .in_rd(in_rd), .In(In),
    .in_empty(in_empty), .Int(Int), .rd_err(rd_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] q[$];
  logic        m_err  = 1'b0;
  logic        m_prev = 1'b0;
  logic        m_pend = 1'b0;
  int          m_fire = -1000;
  int          cyc    = 0;
  int          pulses = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge of the reference: FIFO as a queue, interrupt as "time of
  // last pulse" plus a pending bit; busy until HOLDOFF+1 edges after a pulse.
  task automatic model_edge();
    bit rise;
    int sz;
    cyc++;
    if (!Rst) begin
      q.delete();
      m_err  = 1'b0;
      m_pend = 1'b0;
      m_fire = -1000;
      m_prev = irq_req;
    end else begin
      rise = irq_req && !m_prev;
      sz   = q.size();
      if (in_rd && sz == 0) m_err = 1'b1;
      if (in_rd && sz > 0) void'(q.pop_front());
      if (dev_valid && sz < DEPTH) q.push_back(dev_data);
      m_prev = irq_req;
      if (cyc == m_fire + HOLDOFF + 1) begin
        if (m_pend || rise) m_fire = cyc;
        m_pend = 1'b0;
      end else if (cyc < m_fire + HOLDOFF + 1) begin
        if (rise) m_pend = 1'b1;
      end else if (rise) begin
        m_fire = cyc;
      end
    end
  endtask

  task automatic compare_all();
    check_val("in_bus",    32'(In),        (q.size() > 0) ? 32'(q[0]) : 32'h0);
    check_val("in_empty",  32'(in_empty),  32'(q.size() == 0));
    check_val("dev_ready", 32'(dev_ready), 32'(q.size() != DEPTH));
    check_val("int",       32'(Int),       32'(m_fire == cyc));
    check_val("rd_err",    32'(rd_err),    32'(m_err));
  endtask

  task automatic step(input logic r, input logic dv, input logic [15:0] dd,
                      input logic rd, input logic irq);
    @(negedge Clk);
    Rst = r; dev_valid = dv; dev_data = dd; in_rd = rd; irq_req = irq;
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
    if (Int === 1'b1) pulses++;
  endtask

  initial begin
    int first_p;
    int second_p;
    logic [15:0] hold_data;
    logic        hold_valid;
    logic        dv;
    logic        rd;
    logic        irq;
    logic        r;

    // reset state
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    check_val("rst_empty", 32'(in_empty), 32'h1);
    check_val("rst_in", 32'(In), 32'h0);

    // fill to full, fifth word refused
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    check_val("full_ready", 32'(dev_ready), 32'h0);
    step(1'b1, 1'b1, 16'hA005, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hA005, 1'b0, 1'b0);
    check_val("full_head", 32'(In), 32'hA001);

    // pop from full while device holds A005
    step(1'b1, 1'b1, 16'hA005, 1'b1, 1'b0);
    check_val("pop_head", 32'(In), 32'hA002);
    step(1'b1, 1'b1, 16'hA005, 1'b0, 1'b0);
    check_val("refill_ready", 32'(dev_ready), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    check_val("drained", 32'(in_empty), 32'h1);

    // read on empty with simultaneous push
    step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0);
    check_val("rderr_set", 32'(rd_err), 32'h1);
    check_val("rderr_word", 32'(In), 32'h1234);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);

    // two edges two cycles apart: second pulse delayed by hold-off
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    first_p = -1; second_p = -1;
    for (int i = 0; i < 12; i++) begin
      irq = (i == 0 || i == 2);
      step(1'b1, 1'b0, 16'h0, 1'b0, irq);
      if (Int === 1'b1) begin
        if (first_p < 0) first_p = i;
        else if (second_p < 0) second_p = i;
      end
    end
    check_val("irq_first", 32'(first_p), 32'd0);
    check_val("irq_gap", 32'(second_p - first_p), 32'(HOLDOFF + 1));

    // level held high: one pulse only
    pulses = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check_val("level_pulses", 32'(pulses), 32'd1);

    // reset mid-activity: 3 words, FSM in HOLD with pending
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'hCCCC, 1'b1, 1'b0);
    check_val("rstmid_empty", 32'(in_empty), 32'h1);
    check_val("rstmid_in", 32'(In), 32'h0);
    check_val("rstmid_int", 32'(Int), 32'h0);
    check_val("rstmid_rderr", 32'(rd_err), 32'h0);
    pulses = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check_val("rstmid_nopulse", 32'(pulses), 32'd0);

    // irq high across reset release: no pulse
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    check_val("rst_level_nofire", 32'(pulses), 32'd0);

    // random traffic; device honours the handshake by holding refused data
    hold_valid = 1'b0;
    hold_data  = '0;
    irq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      if (hold_valid) begin
        dv = 1'b1;
      end else begin
        dv = ($urandom_range(0, 99) < 50);
        hold_data = 16'($urandom);
      end
      rd = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 99) < 30) irq = ~irq;
      hold_valid = dv && !dev_ready && r;
      step(r, dv, hold_data, rd, irq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
